// File: rtl/vga_timing_gen_pkg.sv
// Shared timing constants and types for the 640x480@60 Hz VGA raster generator.
// The top-level parameters default to these values.
package vga_pkg;

    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;
    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;

    localparam int H_TOTAL      = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL      = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int H_SYNC_START = H_ACTIVE + H_FP;
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
    localparam int V_SYNC_START = V_ACTIVE + V_FP;
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

    localparam logic SYNC_ACTIVE = 1'b0;
    localparam int   COUNT_W     = 11;

    typedef logic [COUNT_W-1:0] count_t;

    typedef struct packed {
        logic hSync;
        logic vSync;
        logic blankN;
    } sync_t;

    // Idle level for the sync bundle: both syncs deasserted, picture blanked.
    localparam sync_t SYNC_IDLE = '{hSync: ~SYNC_ACTIVE, vSync: ~SYNC_ACTIVE, blankN: 1'b0};

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle handed from the timing generator to the draw stages.
interface vga_timing_gen_if;
    import vga_pkg::*;

    count_t pixelX;
    count_t pixelY;
    logic   hSync;
    logic   vSync;
    logic   blankN;
    logic   startOfFrame;
    logic   endOfFrame;

    modport master (
        output pixelX, pixelY, hSync, vSync, blankN, startOfFrame, endOfFrame
    );

    modport slave (
        input pixelX, pixelY, hSync, vSync, blankN, startOfFrame, endOfFrame
    );

endinterface

// File: rtl/vga_timing_gen_sync_delay_line.sv
// Fixed-depth shift register that keeps the sync bundle aligned with the
// registered pixel data of the downstream draw stages.
module sync_delay_line #(
    parameter int               WIDTH     = 3,
    parameter int               DEPTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] dout_o
);

    logic [WIDTH-1:0] stage_q [DEPTH];

    always_ff @(posedge clk) begin
        if (!resetN) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= RESET_VAL;
            end
        end else begin
            stage_q[0] <= din_i;
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign dout_o = stage_q[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// Raster counters, sync/blank decode and frame-boundary pulses for the VGA chain.
// PIPE_DELAY (legal 1..4) matches the latency of the registered RGB path.
module vga_timing_gen #(
    parameter int H_ACTIVE   = vga_pkg::H_ACTIVE,
    parameter int H_FP       = vga_pkg::H_FP,
    parameter int H_SYNC     = vga_pkg::H_SYNC,
    parameter int H_BP       = vga_pkg::H_BP,
    parameter int V_ACTIVE   = vga_pkg::V_ACTIVE,
    parameter int V_FP       = vga_pkg::V_FP,
    parameter int V_SYNC     = vga_pkg::V_SYNC,
    parameter int V_BP       = vga_pkg::V_BP,
    parameter int PIPE_DELAY = 1
) (
    input  logic             clk,
    input  logic             resetN,
    vga_timing_gen_if.master vga
);

    localparam vga_pkg::count_t X_LAST     = vga_pkg::count_t'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam vga_pkg::count_t Y_LAST     = vga_pkg::count_t'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam vga_pkg::count_t Y_ACT_LAST = vga_pkg::count_t'(V_ACTIVE - 1);
    localparam vga_pkg::count_t X_ACTIVE   = vga_pkg::count_t'(H_ACTIVE);
    localparam vga_pkg::count_t Y_ACTIVE   = vga_pkg::count_t'(V_ACTIVE);
    localparam vga_pkg::count_t HS_FIRST   = vga_pkg::count_t'(H_ACTIVE + H_FP);
    localparam vga_pkg::count_t HS_LAST    = vga_pkg::count_t'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam vga_pkg::count_t VS_FIRST   = vga_pkg::count_t'(V_ACTIVE + V_FP);
    localparam vga_pkg::count_t VS_LAST    = vga_pkg::count_t'(V_ACTIVE + V_FP + V_SYNC - 1);

    vga_pkg::count_t pixelX_q, pixelX_d;
    vga_pkg::count_t pixelY_q, pixelY_d;
    logic            startOfFrame_q, startOfFrame_d;
    logic            endOfFrame_q, endOfFrame_d;
    logic            lineEnd;
    vga_pkg::sync_t  rawSync;
    vga_pkg::sync_t  delayedSync;

    // Frame pulses are taken from the same transition that moves the counters,
    // so they line up with the (0,0) and (0,V_ACTIVE) positions they announce.
    always_comb begin
        lineEnd        = (pixelX_q == X_LAST);
        pixelX_d       = pixelX_q + 1'b1;
        pixelY_d       = pixelY_q;
        startOfFrame_d = 1'b0;
        endOfFrame_d   = 1'b0;
        if (lineEnd) begin
            pixelX_d       = '0;
            pixelY_d       = (pixelY_q == Y_LAST) ? '0 : pixelY_q + 1'b1;
            startOfFrame_d = (pixelY_q == Y_LAST);
            endOfFrame_d   = (pixelY_q == Y_ACT_LAST);
        end
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            pixelX_q       <= '0;
            pixelY_q       <= '0;
            startOfFrame_q <= 1'b0;
            endOfFrame_q   <= 1'b0;
        end else begin
            pixelX_q       <= pixelX_d;
            pixelY_q       <= pixelY_d;
            startOfFrame_q <= startOfFrame_d;
            endOfFrame_q   <= endOfFrame_d;
        end
    end

    always_comb begin
        rawSync        = vga_pkg::SYNC_IDLE;
        rawSync.hSync  = (pixelX_q >= HS_FIRST && pixelX_q <= HS_LAST) ?
                         vga_pkg::SYNC_ACTIVE : ~vga_pkg::SYNC_ACTIVE;
        rawSync.vSync  = (pixelY_q >= VS_FIRST && pixelY_q <= VS_LAST) ?
                         vga_pkg::SYNC_ACTIVE : ~vga_pkg::SYNC_ACTIVE;
        rawSync.blankN = (pixelX_q < X_ACTIVE) && (pixelY_q < Y_ACTIVE);
    end

    sync_delay_line #(
        .WIDTH     (3),
        .DEPTH     (PIPE_DELAY),
        .RESET_VAL (vga_pkg::SYNC_IDLE)
    ) u_syncDelay (
        .clk    (clk),
        .resetN (resetN),
        .din_i  (rawSync),
        .dout_o (delayedSync)
    );

    assign vga.pixelX       = pixelX_q;
    assign vga.pixelY       = pixelY_q;
    assign vga.hSync        = delayedSync.hSync;
    assign vga.vSync        = delayedSync.vSync;
    assign vga.blankN       = delayedSync.blankN;
    assign vga.startOfFrame = startOfFrame_q;
    assign vga.endOfFrame   = endOfFrame_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: full-size instances with delays 1 and 3 plus a
// shrunken-timing instance so whole frames fit in a short run.
module tb_vga_timing_gen;
    import vga_pkg::*;

    typedef struct {
        int ha, hf, hs, hb, va, vf, vs, vb, d;
    } timing_t;

    logic clk;
    logic resetNA;
    logic resetNC;

    int checks = 0;
    int errors = 0;
    int tA = 0;
    int tC = 0;
    int cLeft = 0;

    timing_t tmA, tmB, tmC;

    logic aPrevHs, aInPulse, bPrevHs, bInPulse, cPrevVs, cInPulse;
    int   aLow, bLow, cLow;
    int   cLastSof;

    vga_timing_gen_if ifA ();
    vga_timing_gen_if ifB ();
    vga_timing_gen_if ifC ();

    vga_timing_gen #(.PIPE_DELAY(1)) dutA (.clk(clk), .resetN(resetNA), .vga(ifA));
    vga_timing_gen #(.PIPE_DELAY(3)) dutB (.clk(clk), .resetN(resetNA), .vga(ifB));
    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(3),
        .PIPE_DELAY(2)
    ) dutC (.clk(clk), .resetN(resetNC), .vga(ifC));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkVal(input string tag, input logic [10:0] obs, input logic [10:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic checkBit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic checkInt(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: t counts clocks since reset release; everything follows from t.
    task automatic checkOutput(input string name, input timing_t tm, input int t,
                               input logic [10:0] x, input logic [10:0] y,
                               input logic hs, input logic vs, input logic bn,
                               input logic sof, input logic eof);
        int   ht, vt, frame, tp, px, py;
        logic ehs, evs, ebn;
        ht    = tm.ha + tm.hf + tm.hs + tm.hb;
        vt    = tm.va + tm.vf + tm.vs + tm.vb;
        frame = ht * vt;
        ehs   = 1'b1;
        evs   = 1'b1;
        ebn   = 1'b0;
        if (t >= tm.d) begin
            tp  = t - tm.d;
            px  = tp % ht;
            py  = (tp / ht) % vt;
            ehs = !(px >= tm.ha + tm.hf && px < tm.ha + tm.hf + tm.hs);
            evs = !(py >= tm.va + tm.vf && py < tm.va + tm.vf + tm.vs);
            ebn = (px < tm.ha) && (py < tm.va);
        end
        checkVal({name, ".pixelX"}, x, 11'(t % ht));
        checkVal({name, ".pixelY"}, y, 11'((t / ht) % vt));
        checkBit({name, ".hSync"}, hs, ehs);
        checkBit({name, ".vSync"}, vs, evs);
        checkBit({name, ".blankN"}, bn, ebn);
        checkBit({name, ".startOfFrame"}, sof, (t > 0) && (t % frame == 0));
        checkBit({name, ".endOfFrame"}, eof, (t > 0) && (t % frame == ht * tm.va));
    endtask

    // Tracks one active-low pulse: position of its falling edge and its width.
    task automatic trackLow(input string tag, input logic running, input logic sig,
                            input logic [10:0] x, input int expX, input int expW,
                            inout logic prev, inout logic inPulse, inout int low);
        if (!running) begin
            inPulse = 1'b0;
            low     = 0;
        end else begin
            if (!sig && prev) begin
                checkVal({tag, "FallX"}, x, 11'(expX));
                inPulse = 1'b1;
                low     = 0;
            end
            if (!sig) low++;
            if (sig && !prev && inPulse) checkInt({tag, "Width"}, low, expW);
        end
        prev = sig;
    endtask

    task automatic step();
        logic rA, rC;
        rA = resetNA;
        rC = resetNC;
        @(posedge clk);
        tA = rA ? tA + 1 : 0;
        tC = rC ? tC + 1 : 0;
        @(negedge clk);
        checkOutput("A", tmA, tA, ifA.pixelX, ifA.pixelY, ifA.hSync, ifA.vSync,
                    ifA.blankN, ifA.startOfFrame, ifA.endOfFrame);
        checkOutput("B", tmB, tA, ifB.pixelX, ifB.pixelY, ifB.hSync, ifB.vSync,
                    ifB.blankN, ifB.startOfFrame, ifB.endOfFrame);
        checkOutput("C", tmC, tC, ifC.pixelX, ifC.pixelY, ifC.hSync, ifC.vSync,
                    ifC.blankN, ifC.startOfFrame, ifC.endOfFrame);
        trackLow("A.hSync", rA, ifA.hSync, ifA.pixelX, 657, 96, aPrevHs, aInPulse, aLow);
        trackLow("B.hSync", rA, ifB.hSync, ifB.pixelX, 659, 96, bPrevHs, bInPulse, bLow);
        trackLow("C.vSync", rC, ifC.vSync, ifC.pixelX, 2, 32, cPrevVs, cInPulse, cLow);
        if (!rC) begin
            cLastSof = 0;
        end else begin
            if (ifC.endOfFrame) checkInt("C.eofOffset", tC - cLastSof, 96);
            if (ifC.startOfFrame) begin
                checkInt("C.sofGap", tC - cLastSof, 208);
                cLastSof = tC;
            end
        end
    endtask

    // Small instance gets occasional short random resets while everything runs.
    task automatic applyStimulus(input int n);
        for (int i = 0; i < n; i++) begin
            if (cLeft > 0) begin
                resetNC = 1'b0;
                cLeft--;
            end else begin
                resetNC = 1'b1;
                if ($urandom_range(0, 499) == 0) cLeft = $urandom_range(1, 3);
            end
            step();
        end
    endtask

    initial begin
        tmA = '{H_ACTIVE, H_FP, H_SYNC, H_BP, V_ACTIVE, V_FP, V_SYNC, V_BP, 1};
        tmB = '{H_ACTIVE, H_FP, H_SYNC, H_BP, V_ACTIVE, V_FP, V_SYNC, V_BP, 3};
        tmC = '{8, 2, 3, 3, 6, 2, 2, 3, 2};
        aPrevHs = 1'b1; aInPulse = 1'b0; aLow = 0;
        bPrevHs = 1'b1; bInPulse = 1'b0; bLow = 0;
        cPrevVs = 1'b1; cInPulse = 1'b0; cLow = 0;
        cLastSof = 0;
        resetNA = 1'b0;
        resetNC = 1'b0;

        for (int i = 0; i < 5; i++) step();
        resetNA = 1'b1;
        resetNC = 1'b1;

        // Thirteen full lines plus 300 pixels: covers the (799,10) wrap.
        applyStimulus(800 * 13 + 300);

        resetNA = 1'b0;
        resetNC = 1'b0;
        step();
        resetNA = 1'b1;
        applyStimulus(2000);

        applyStimulus($urandom_range(1, 800));
        resetNA = 1'b0;
        for (int i = 0; i < int'($urandom_range(1, 3)); i++) step();
        resetNA = 1'b1;
        applyStimulus(1700);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
